// File: rtl/msrv32_pkg.sv
// ---------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the MSRV32 program-counter generator.
//   XLEN              : architectural register / address width
//   BOOT_ADDR_DEFAULT : default first fetch address after reset
//   pc_state_e        : PC generator FSM state (ST_BOOT / ST_RUN)
//   clear_lsb()       : forces bit 0 of a jump target to zero (JALR rule)
// ---------------------------------------------------------------------------
package msrv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

  // Masking (rather than slicing) keeps every input bit in use.
  function automatic logic [XLEN-1:0] clear_lsb(input logic [XLEN-1:0] addr);
    return addr & ~{{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/msrv32_next_pc_mux.sv
// ---------------------------------------------------------------------------
// msrv32_next_pc_mux
// Combinational next-PC priority selector.
// Priority while running: trap > mret > taken branch > sequential (pc+4).
// While booting the boot address is selected unconditionally.
//
// Configuration macro: MSRV32_MISALIGN_CHECK_EN
//   defined   : a taken branch whose target has bit 1 set is flagged on
//               misaligned_o and pc+4 is selected instead; the trap unit
//               redirects the fetch on the following cycle.
//   undefined : misaligned_o is tied low and targets are used unchecked.
//
// Ports
//   run_i          in   1      FSM is in ST_RUN
//   boot_addr_i    in   XLEN   boot address
//   pc_plus_4_i    in   XLEN   sequential next address
//   branch_taken_i in   1      taken branch / jump
//   target_addr_i  in   XLEN   branch / jump target
//   trap_taken_i   in   1      trap entry
//   trap_addr_i    in   XLEN   trap vector
//   mret_i         in   1      return from trap
//   epc_i          in   XLEN   saved exception PC
//   next_pc_o      out  XLEN   selected next fetch address
//   misaligned_o   out  1      taken target not 4-byte aligned
// ---------------------------------------------------------------------------
module msrv32_next_pc_mux
  import msrv32_pkg::*;
(
  input  logic            run_i,
  input  logic [XLEN-1:0] boot_addr_i,
  input  logic [XLEN-1:0] pc_plus_4_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] target_addr_i,
  input  logic            trap_taken_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] epc_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

`ifdef MSRV32_MISALIGN_CHECK_EN
  // Only a branch that would actually be taken can be misaligned;
  // trap and mret override it.
  assign misaligned_o = run_i & branch_taken_i & ~trap_taken_i & ~mret_i &
                        target_addr_i[1];
`else
  assign misaligned_o = 1'b0;
`endif

  always_comb begin
    next_pc_o = pc_plus_4_i;
    if (!run_i) begin
      next_pc_o = boot_addr_i;
    end else if (trap_taken_i) begin
      next_pc_o = trap_addr_i;
    end else if (mret_i) begin
      next_pc_o = epc_i;
    end else if (branch_taken_i && !misaligned_o) begin
      next_pc_o = clear_lsb(target_addr_i);
    end
  end

endmodule

// File: rtl/msrv32_pc_gen.sv
// ---------------------------------------------------------------------------
// msrv32_pc_gen
// Program-counter generator: boot/run FSM, the single PC register and the
// fetch-address output. The next-PC selection lives in msrv32_next_pc_mux.
//
// Configuration macro: MSRV32_MISALIGN_CHECK_EN (see msrv32_next_pc_mux).
//
// Handshake: the instruction bus accepts the address on i_addr_out at a
// rising edge where ahb_ready_in=1; only then does pc_out (and the FSM)
// advance. With ahb_ready_in=0 everything registered holds, while
// i_addr_out and misaligned_instr_out keep following the inputs.
//
// Ports
//   clk_in               in   1   clock, rising edge
//   rst_n_in             in   1   asynchronous active-low reset
//   ahb_ready_in         in   1   bus ready; low stalls the PC
//   branch_taken_in      in   1   taken branch / JAL / JALR
//   target_addr_in       in   32  branch / jump target
//   trap_taken_in        in   1   trap / interrupt entry
//   trap_addr_in         in   32  trap vector
//   mret_in              in   1   return from trap
//   epc_in               in   32  saved exception PC
//   i_addr_out           out  32  next fetch address (combinational)
//   pc_out               out  32  current instruction PC (registered)
//   pc_plus_4_out        out  32  pc_out + 4, wrapping
//   pc_valid_out         out  1   pc_out holds a fetched instruction's PC
//   misaligned_instr_out out  1   taken target not 4-byte aligned
//   state_dbg_out        out  1   FSM state (0 = ST_BOOT, 1 = ST_RUN)
// ---------------------------------------------------------------------------
module msrv32_pc_gen
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ahb_ready_in,
  input  logic        branch_taken_in,
  input  logic [31:0] target_addr_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_addr_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  output logic [31:0] i_addr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic        pc_valid_out,
  output logic        misaligned_instr_out,
  output logic        state_dbg_out
);

  pc_state_e         state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   next_pc;
  logic [XLEN-1:0]   pc_plus_4;
  logic              run;

  assign pc_plus_4 = pc_q + 32'd4;
  assign run       = (state_q == ST_RUN);

  // FSM: state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: if (ahb_ready_in) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pc_valid_out  = 1'b0;
    state_dbg_out = state_q;
    if (state_q == ST_RUN) pc_valid_out = 1'b1;
  end

  msrv32_next_pc_mux u_next_pc_mux (
    .run_i          (run),
    .boot_addr_i    (BOOT_ADDR),
    .pc_plus_4_i    (pc_plus_4),
    .branch_taken_i (branch_taken_in),
    .target_addr_i  (target_addr_in),
    .trap_taken_i   (trap_taken_in),
    .trap_addr_i    (trap_addr_in),
    .mret_i         (mret_in),
    .epc_i          (epc_in),
    .next_pc_o      (next_pc),
    .misaligned_o   (misaligned_instr_out)
  );

  // PC register: loads the fetch address the bus accepted this cycle.
  assign pc_d = ahb_ready_in ? next_pc : pc_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q <= BOOT_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign i_addr_out    = next_pc;
  assign pc_out        = pc_q;
  assign pc_plus_4_out = pc_plus_4;

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_msrv32_pc_gen
// Directed + randomized bench for msrv32_pc_gen (BOOT_ADDR = 0).
// Expected PCs are pushed to exp_q when a cycle is driven and popped and
// compared after the rising edge.
// ---------------------------------------------------------------------------
module tb_msrv32_pc_gen;

  localparam logic [31:0] BOOT = 32'h0000_0000;
`ifdef MSRV32_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        ahb_ready, branch_taken, trap_taken, mret;
  logic [31:0] target_addr, trap_addr, epc;
  logic [31:0] i_addr, pc, pc_plus_4;
  logic        pc_valid, misaligned, state_dbg;

  msrv32_pc_gen #(.BOOT_ADDR(BOOT)) dut (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .ahb_ready_in         (ahb_ready),
    .branch_taken_in      (branch_taken),
    .target_addr_in       (target_addr),
    .trap_taken_in        (trap_taken),
    .trap_addr_in         (trap_addr),
    .mret_in              (mret),
    .epc_in               (epc),
    .i_addr_out           (i_addr),
    .pc_out               (pc),
    .pc_plus_4_out        (pc_plus_4),
    .pc_valid_out         (pc_valid),
    .misaligned_instr_out (misaligned),
    .state_dbg_out        (state_dbg)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] pc_m;   // bench's own copy of the PC

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Apply inputs (called just after a rising edge) and let them settle.
  task automatic drv(input logic rdy, input logic br, input logic [31:0] tgt,
                     input logic trp, input logic [31:0] taddr,
                     input logic mr, input logic [31:0] ep);
    ahb_ready    = rdy;
    branch_taken = br;
    target_addr  = tgt;
    trap_taken   = trp;
    trap_addr    = taddr;
    mret         = mr;
    epc          = ep;
    #1;
  endtask

  // Reference next-PC for the running state.
  function automatic logic [31:0] model_next(input logic [31:0] cur);
    logic mis;
    mis = MIS_EN && branch_taken && !trap_taken && !mret && target_addr[1];
    if (trap_taken)                return trap_addr;
    else if (mret)                 return epc;
    else if (branch_taken && !mis) return {target_addr[31:1], 1'b0};
    else                           return cur + 32'd4;
  endfunction

  // Push the expected PC, clock once, pop and compare.
  task automatic tick(input logic [31:0] exp_pc);
    logic [31:0] e;
    exp_q.push_back(exp_pc);
    pc_m = exp_pc;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("pc_out", pc, e);
    end
  endtask

  // Redirect to an aligned address with one taken branch.
  task automatic jump(input logic [31:0] a);
    drv(1, 1, a, 0, 0, 0, 0);
    tick(a);
  endtask

  initial begin
    logic [31:0] nxt;
    logic        rdy, br, trp, mr;
    logic [31:0] tgt, ta, ep;

    // reset state
    rst_n = 1'b0;
    drv(1, 1, 32'h22, 0, 0, 0, 0);
    #1;
    chk("rst_pc", pc, BOOT);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_state", {31'd0, state_dbg}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("boot_i_addr_ignores_branch", i_addr, BOOT);

    // boot cycle, ready high
    drv(1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #0.5;
    chk("boot_i_addr", i_addr, BOOT);
    tick(BOOT);
    chk("run_valid", {31'd0, pc_valid}, 32'd1);
    chk("run_state", {31'd0, state_dbg}, 32'd1);
    chk("run_i_addr", i_addr, BOOT + 32'd4);
    chk("run_pc_plus_4", pc_plus_4, BOOT + 32'd4);

    // sequential fetch
    drv(1, 0, 0, 0, 0, 0, 0);
    tick(32'h4);
    tick(32'h8);

    // stall at 0x40 for 3 cycles, then resume
    jump(32'h40);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("stall_i_addr", i_addr, 32'h44);
    tick(32'h40);
    tick(32'h40);
    tick(32'h40);
    chk("stall_valid", {31'd0, pc_valid}, 32'd1);
    drv(1, 0, 0, 0, 0, 0, 0);
    tick(32'h44);

    // branch with odd target: bit 0 cleared
    jump(32'h100);
    drv(1, 1, 32'h201, 0, 0, 0, 0);
    chk("branch_i_addr", i_addr, 32'h200);
    chk("branch_misaligned", {31'd0, misaligned}, 32'd0);
    tick(32'h200);

    // trap + mret + branch together: trap wins
    jump(32'h100);
    drv(1, 1, 32'h600, 1, 32'h80, 1, 32'h500);
    chk("trap_i_addr", i_addr, 32'h80);
    tick(32'h80);

    // mret + branch: mret wins
    drv(1, 1, 32'h600, 0, 32'h80, 1, 32'h500);
    chk("mret_i_addr", i_addr, 32'h500);
    tick(32'h500);

    // misaligned branch target
    jump(32'h10);
    drv(1, 1, 32'h22, 0, 0, 0, 0);
    chk("mis_flag", {31'd0, misaligned}, {31'd0, MIS_EN});
    chk("mis_i_addr", i_addr, MIS_EN ? 32'h14 : 32'h22);
    drv(0, 1, 32'h22, 0, 0, 0, 0);
    chk("mis_flag_stalled", {31'd0, misaligned}, {31'd0, MIS_EN});
    tick(32'h10);
    drv(1, 1, 32'h22, 0, 0, 0, 0);
    tick(MIS_EN ? 32'h14 : 32'h22);
    // trap suppresses the misaligned flag
    drv(1, 1, 32'h22, 1, 32'h90, 0, 0);
    chk("mis_trap_flag", {31'd0, misaligned}, 32'd0);
    tick(32'h90);

    // wrap at the top of the address space
    jump(32'hFFFF_FFFC);
    drv(1, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc_plus_4", pc_plus_4, 32'h0);
    chk("wrap_i_addr", i_addr, 32'h0);
    tick(32'h0);

    // randomized run against the reference model
    for (int i = 0; i < 40; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      br  = $urandom_range(0, 1);
      trp = ($urandom_range(0, 5) == 0);
      mr  = ($urandom_range(0, 5) == 0);
      tgt = $urandom;
      ta  = $urandom & 32'hFFFF_FFFC;
      ep  = $urandom & 32'hFFFF_FFFC;
      drv(rdy, br, tgt, trp, ta, mr, ep);
      nxt = model_next(pc_m);
      chk("rand_i_addr", i_addr, nxt);
      chk("rand_misaligned", {31'd0, misaligned},
          {31'd0, MIS_EN && br && !trp && !mr && tgt[1]});
      tick(rdy ? nxt : pc_m);
    end

    // asynchronous reset mid-cycle at 0x300
    jump(32'h300);
    drv(1, 1, 32'h22, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", pc, BOOT);
    chk("midrst_valid", {31'd0, pc_valid}, 32'd0);
    chk("midrst_state", {31'd0, state_dbg}, 32'd0);
    chk("midrst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("midrst_i_addr", i_addr, BOOT);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // boot holds while the bus is not ready
    drv(0, 0, 0, 0, 0, 0, 0);
    tick(BOOT);
    chk("boot_hold_state", {31'd0, state_dbg}, 32'd0);
    chk("boot_hold_valid", {31'd0, pc_valid}, 32'd0);
    drv(1, 0, 0, 0, 0, 0, 0);
    tick(BOOT);
    chk("reboot_state", {31'd0, state_dbg}, 32'd1);
    tick(BOOT + 32'd4);

    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
